mul_div_unit: RTL and testbench

- Parametrised multicycle multiply/divide unit with architectural HI/LO registers for the MIPS150 datapath.
- Replaces the single-cycle multiply/divide and HI/LO handling in the combinational ALU.
- Adds signed/unsigned iterative multiply and divide, a start/busy/done handshake, and defined divide-by-zero results.
- Sits beside the ALU in EX. The control unit stalls the pipeline while busy=1; MFHI/MFLO read the hi/lo outputs directly.

---
 rtl/mul_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: multicycle multiply/divide unit with architectural HI/LO registers.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - synchronous active-high reset, aborts any in-flight operation
//   start  - request, sampled only while busy=0
//   op     - 0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   a, b   - operands (multiplicand/multiplier, dividend/divisor, MTHI/MTLO source in a)
//   busy   - an iterative operation is in progress; starts are ignored
//   done   - one-cycle pulse, hi/lo were just written by a MULT/DIV-class op
//   hi, lo - HI/LO registers (product upper/lower half, remainder/quotient)
//
// Build option: define FAST_MUL_EN to make MULT/MULTU complete at the accepting edge
// with a combinational product; DIV/DIVU stay iterative.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] acc_q;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor magnitude
    logic               is_div_q;
    logic               neg_res_q;  // negate product / quotient
    logic               neg_rem_q;  // remainder follows dividend sign
    logic               dbz_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    // Request decode and operand magnitudes
    logic             op_mul, op_div, op_signed, a_neg, b_neg, iter_op;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        op_mul    = (op == 3'd0) || (op == 3'd1);
        op_div    = (op == 3'd2) || (op == 3'd3);
        op_signed = (op == 3'd0) || (op == 3'd2);
        a_neg     = op_signed & a[WIDTH-1];
        b_neg     = op_signed & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
`ifdef FAST_MUL_EN
        iter_op   = op_div;
`else
        iter_op   = op_div | op_mul;
`endif
    end

`ifdef FAST_MUL_EN
    // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of the product correct for both
    // signed and unsigned operands.
    logic [2*WIDTH-1:0] fast_prod;
    always_comb begin
        fast_prod = {{WIDTH{a_neg}}, a} * {{WIDTH{b_neg}}, b};
    end
`endif

    // One iteration: shift-add for multiply, restoring step for divide
    logic [WIDTH:0]     mul_sum, div_trial, div_diff;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_trial = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, opb_q};
        if (is_div_q) begin
            if (div_diff[WIDTH]) begin
                acc_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign fix applied in StFix. Overflow (most-negative / -1) needs no special case:
    // the magnitude quotient 2^(WIDTH-1) negates to itself.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = dbz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
        // With a zero divisor the remainder magnitude is |a|, so this restores hi=a.
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (iter_op) begin
                            cnt_q     <= '0;
                            is_div_q  <= op_div;
                            neg_res_q <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            dbz_q     <= op_div && (b == '0);
                            opb_q     <= op_div ? b_mag : a_mag;
                            acc_q     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        end
`ifdef FAST_MUL_EN
                        if (op_mul) begin
                            {hi_q, lo_q} <= fast_prod;
                            done_q       <= 1'b1;
                        end
`endif
                        if (op == 3'd4) hi_q <= a;
                        if (op == 3'd5) lo_q <= a;
                    end
                end
                StRun: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CntW'(1);
                end
                StFix: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start && iter_op) state_d = StRun;
            StRun:   if (cnt_q == CntLast) state_d = StFix;
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != StIdle);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32): directed vector table, hand-written
// multi-cycle sequences, and random ops checked against an arithmetic reference model.
module tb_mul_div_unit;
    localparam int unsigned W = 32;
`ifdef FAST_MUL_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (o)
            3'd0: model = sx * sy;
            3'd1: model = ux * uy;
            3'd2: begin
                if (y == 32'h0) model = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    model = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'h0) model = {x, 32'hFFFF_FFFF};
                else model = {(x % y), (x / y)};
            end
        endcase
    endfunction

    // Issue one MULT/DIV-class op in the current cycle, wait for done, check everything.
    // Returns in the done cycle so a following op exercises back-to-back acceptance.
    task automatic run_op(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] ehi, input logic [31:0] elo, input string name);
        logic [31:0] hi0, lo0;
        int k, busy_n;
        bit stable, fast_op;
        fast_op = Fast && (o <= 3'd1);
        hi0 = hi;
        lo0 = lo;
        start = 1'b1;
        op = o;
        a = ia;
        b = ib;
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        if (!fast_op) check({name, " done low after accept"}, done, 1'b0);
        k = 0;
        busy_n = 0;
        stable = 1'b1;
        while (!done && k < 100) begin
            if (busy) busy_n++;
            if (hi !== hi0 || lo !== lo0) stable = 1'b0;
            tick();
            k++;
        end
        check({name, " latency"}, k, fast_op ? 0 : W + 1);
        check({name, " busy cycles"}, busy_n, fast_op ? 0 : W + 1);
        check({name, " busy at done"}, busy, 1'b0);
        check({name, " hi/lo stable while busy"}, stable, 1'b1);
        check({name, " hi"}, hi, ehi);
        check({name, " lo"}, lo, elo);
    endtask

    // Single-cycle MTHI/MTLO/no-op in IDLE
    task automatic move_op(input logic [2:0] o, input logic [31:0] val, input logic [31:0] ehi,
                           input logic [31:0] elo, input string name);
        start = 1'b1;
        op = o;
        a = val;
        b = $urandom;
        tick();
        start = 1'b0;
        check({name, " busy"}, busy, 1'b0);
        check({name, " done"}, done, 1'b0);
        check({name, " hi"}, hi, ehi);
        check({name, " lo"}, lo, elo);
    endtask

    initial begin
        vec_t vecs[9];
        logic [63:0] exp;
        logic [2:0]  o;
        logic [31:0] ia, ib, ehi, elo;
        int k, r;
        bit seen;

        vecs[0] = '{"mult_neg3x5",   3'd0, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{"multu_max_x2",  3'd1, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{"div_neg7_2",    3'd2, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"divu_by_zero",  3'd3, 32'h7,         32'h0,         32'h0000_0007, 32'hFFFF_FFFF};
        vecs[4] = '{"div_overflow",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[5] = '{"div_neg_by_0",  3'd2, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[6] = '{"mult_minsq",    3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
        vecs[7] = '{"div_7_neg2",    3'd2, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
        vecs[8] = '{"mult_6x7",      3'd0, 32'h6,         32'h7,         32'h0,         32'd42};

        rst = 1'b1;
        start = 1'b0;
        op = 3'd0;
        a = '0;
        b = '0;
        repeat (2) tick();
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        rst = 1'b0;

        move_op(3'd4, 32'h1234_5678, 32'h1234_5678, 32'h0, "mthi");
        move_op(3'd5, 32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0, "mtlo");
        move_op(3'd6, 32'h5555_5555, 32'h1234_5678, 32'h9ABC_DEF0, "nop6");
        move_op(3'd7, 32'hAAAA_AAAA, 32'h1234_5678, 32'h9ABC_DEF0, "nop7");

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo,
                                 vecs[i].name);

        // MTLO/MTHI issued while busy must be ignored
        o   = Fast ? 3'd2 : 3'd0;
        ia  = Fast ? 32'd100 : 32'd6;
        ehi = Fast ? 32'd2 : 32'd0;
        elo = Fast ? 32'd14 : 32'd42;
        start = 1'b1;
        op = o;
        a = ia;
        b = 32'd7;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        op = 3'd5;
        a = 32'hDEAD_BEEF;
        tick();
        op = 3'd4;
        a = 32'hCAFE_F00D;
        tick();
        start = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            tick();
            k++;
        end
        check("inject done seen", done, 1'b1);
        check("inject hi", hi, ehi);
        check("inject lo", lo, elo);

        // Random ops against the reference model
        for (int n = 0; n < 40; n++) begin
            o  = 3'($urandom_range(0, 3));
            ia = $urandom;
            ib = $urandom;
            r  = $urandom_range(0, 7);
            if (r == 0) ib = 32'h0;
            if (r == 1) begin
                ia = 32'h8000_0000;
                ib = 32'hFFFF_FFFF;
            end
            if (r == 2) ib = {28'h0, ib[3:0]};
            exp = model(o, ia, ib);
            run_op(o, ia, ib, exp[63:32], exp[31:0], $sformatf("rand%0d op%0d", n, o));
        end

        // Reset in the middle of a DIV aborts it silently
        move_op(3'd4, 32'h0000_0055, 32'h0000_0055, lo, "mthi before abort");
        start = 1'b1;
        op = 3'd2;
        a = 32'd100;
        b = 32'd7;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("abort no done pulse", seen, 1'b0);
        run_op(3'd1, 32'd3, 32'd4, 32'd0, 32'd12, "multu_after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
